eq_frequency_controller: RTL and testbench

//  Downstream stage of TX channel estimation. Consumes each real-valued pole-frequency

---
 rtl/eq_frequency_controller_if.sv | 32 +++
 rtl/eq_frequency_controller.sv | 167 ++++++++++++++++
 tb/tb_eq_frequency_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_frequency_controller_if.sv
// Handshake bundle between the TX equalizer frequency controller and its
// surroundings (channel-estimate producer and TX equalizer).
//   frequency       real estimate of the pole frequency (Hz)
//   frequency_valid qualifies frequency for one sampled edge
//   eq_code         equalizer code currently offered
//   eq_code_valid   an eq_code offer is pending
//   eq_code_ack     equalizer accepts the pending offer
//   locked          applied code is stable on target
//   busy            controller is not idle
// modport slave  : the controller
// modport master : the estimator / equalizer side
interface eq_frequency_controller_if #(
  parameter int unsigned CODE_W = 6
);
  real               frequency;
  logic              frequency_valid;
  logic [CODE_W-1:0] eq_code;
  logic              eq_code_valid;
  logic              eq_code_ack;
  logic              locked;
  logic              busy;

  modport slave (
    input  frequency, frequency_valid, eq_code_ack,
    output eq_code, eq_code_valid, locked, busy
  );

  modport master (
    output frequency, frequency_valid, eq_code_ack,
    input  eq_code, eq_code_valid, locked, busy
  );
endinterface

// File: rtl/eq_frequency_controller.sv
// Equalizer frequency controller.
// Quantizes each pole-frequency estimate to an equalizer code (round half up,
// clamped to the code range), then walks the applied code toward that target in
// steps of at most STEP_MAX, offering each step to the equalizer with a
// valid/ack handshake and waiting SETTLE_CYCLES after every accepted step.
// Lock is declared after LOCK_COUNT consecutive estimates within HYST of the
// applied code.
// Ports:
//   clk  system clock (posedge)
//   rst  synchronous reset, active-high
//   bus  eq_frequency_controller_if.slave (estimate in, code offer out,
//        ack in, locked/busy status out)
module eq_frequency_controller #(
  parameter int unsigned CODE_W        = 6,
  parameter real         F_MIN         = 1.0e9,
  parameter real         F_STEP        = 0.25e9,
  parameter int unsigned RESET_CODE    = 8,
  parameter int unsigned HYST          = 1,
  parameter int unsigned STEP_MAX      = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_COUNT    = 4
) (
  input logic                      clk,
  input logic                      rst,
  eq_frequency_controller_if.slave bus
);

  localparam int unsigned CODE_MAX = (1 << CODE_W) - 1;
  localparam int unsigned SC_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned LC_W     = $clog2(LOCK_COUNT + 1);

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    WAIT_ACK,
    SETTLE
  } state_t;

  state_t          state_q, state_d;
  code_t           current_q, current_d;
  code_t           target_q, target_d;
  code_t           eq_code_q, eq_code_d;
  logic            eq_code_valid_q, eq_code_valid_d;
  logic            locked_q, locked_d;
  logic [LC_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [SC_W-1:0] settle_cnt_q, settle_cnt_d;

  real             est_scaled;
  code_t           est_code;
  code_t           est_dist;
  code_t           tgt_dist;
  code_t           step_size;
  code_t           step_code;
  logic            est_on_target;
  logic            ack_taken;

  function automatic code_t abs_diff(input code_t a, input code_t b);
    return (a >= b) ? code_t'(a - b) : code_t'(b - a);
  endfunction

  // Round half up: floor(x + 0.5). Clamping happens on the real value, so once
  // the value is known to be inside (0, CODE_MAX) truncation equals floor.
  always_comb begin
    est_scaled = (bus.frequency - F_MIN) / F_STEP + 0.5;
    if (est_scaled <= 0.0) begin
      est_code = '0;
    end else if (est_scaled >= real'(CODE_MAX)) begin
      est_code = code_t'(CODE_MAX);
    end else begin
      est_code = code_t'($rtoi(est_scaled));
    end
  end

  always_comb begin
    est_dist      = abs_diff(est_code, current_q);
    tgt_dist      = abs_diff(target_q, current_q);
    est_on_target = (32'(est_dist) <= HYST);
    step_size     = (32'(tgt_dist) > STEP_MAX) ? code_t'(STEP_MAX) : tgt_dist;
    step_code     = (target_q > current_q) ? code_t'(current_q + step_size)
                                           : code_t'(current_q - step_size);
    ack_taken     = bus.eq_code_ack && eq_code_valid_q;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      current_q       <= code_t'(RESET_CODE);
      target_q        <= code_t'(RESET_CODE);
      eq_code_q       <= code_t'(RESET_CODE);
      eq_code_valid_q <= 1'b0;
      locked_q        <= 1'b0;
      stable_cnt_q    <= '0;
      settle_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      current_q       <= current_d;
      target_q        <= target_d;
      eq_code_q       <= eq_code_d;
      eq_code_valid_q <= eq_code_valid_d;
      locked_q        <= locked_d;
      stable_cnt_q    <= stable_cnt_d;
      settle_cnt_q    <= settle_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.frequency_valid && !est_on_target) state_d = STEP;
      STEP:     state_d = WAIT_ACK;
      WAIT_ACK: if (ack_taken) state_d = SETTLE;
      SETTLE:   if (settle_cnt_q == '0) state_d = (current_q != target_q) ? STEP : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath updates and outputs
  always_comb begin
    current_d       = current_q;
    target_d        = target_q;
    eq_code_d       = eq_code_q;
    eq_code_valid_d = eq_code_valid_q;
    locked_d        = locked_q;
    stable_cnt_d    = stable_cnt_q;
    settle_cnt_d    = settle_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.frequency_valid) begin
          target_d = est_code;
          if (est_on_target) begin
            if (32'(stable_cnt_q) < LOCK_COUNT) stable_cnt_d = stable_cnt_q + 1'b1;
            if (32'(stable_cnt_d) == LOCK_COUNT) locked_d = 1'b1;
          end else begin
            stable_cnt_d = '0;
            locked_d     = 1'b0;
          end
        end
      end
      STEP: begin
        eq_code_d       = step_code;
        eq_code_valid_d = 1'b1;
      end
      WAIT_ACK: begin
        if (ack_taken) begin
          current_d       = eq_code_q;
          eq_code_valid_d = 1'b0;
          settle_cnt_d    = SC_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (settle_cnt_q != '0) settle_cnt_d = settle_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.eq_code       = eq_code_q;
  assign bus.eq_code_valid = eq_code_valid_q;
  assign bus.locked        = locked_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_eq_frequency_controller.sv
module tb_eq_frequency_controller;

  localparam int SETTLE = 16;

  logic clk;
  logic rst;
  logic auto_en;
  logic ack_auto;
  logic ack_man;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    int code;
    bit chk_gap;
  } exp_t;

  exp_t sb[$];

  eq_frequency_controller_if #(.CODE_W(6)) bus ();

  eq_frequency_controller #(
    .CODE_W        (6),
    .F_MIN         (1.0e9),
    .F_STEP        (0.25e9),
    .RESET_CODE    (8),
    .HYST          (1),
    .STEP_MAX      (2),
    .SETTLE_CYCLES (SETTLE),
    .LOCK_COUNT    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.eq_code_ack = auto_en ? ack_auto : ack_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Equalizer model: acknowledges each offer one cycle after seeing it
  initial ack_auto = 1'b0;
  always begin
    @(negedge clk);
    if (bus.eq_code_valid && !bus.eq_code_ack) begin
      @(negedge clk);
      ack_auto = 1'b1;
      @(negedge clk);
      ack_auto = 1'b0;
    end
  end

  // Monitor: compares each new offer against the scoreboard, checks offers are
  // held until accepted, and checks the settle gap between ack and next offer.
  logic       valid_prev;
  logic [5:0] code_prev;
  int         last_ack;
  initial begin
    valid_prev = 1'b0;
    code_prev  = '0;
    last_ack   = 0;
  end
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.eq_code_valid && valid_prev)
      check("offer_hold", int'(bus.eq_code), int'(code_prev));
    if (valid_prev && bus.eq_code_ack) last_ack = cyc;
    if (bus.eq_code_valid && !valid_prev) begin
      check("offer_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("offer_code", int'(bus.eq_code), e.code);
        if (e.chk_gap) check("settle_gap", cyc - last_ack, SETTLE + 1);
      end
    end
    valid_prev = bus.eq_code_valid;
    code_prev  = bus.eq_code;
  end

  task automatic push(input int code, input bit chk_gap);
    exp_t e;
    e.code    = code;
    e.chk_gap = chk_gap;
    sb.push_back(e);
  endtask

  task automatic pulse(input real f);
    bus.frequency       = f;
    bus.frequency_valid = 1'b1;
    @(negedge clk);
    bus.frequency_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, int'(n >= 2000), 0);
  endtask

  task automatic wait_valid(input logic level, input string tag);
    int n;
    n = 0;
    while (bus.eq_code_valid !== level && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, int'(n >= 200), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    rst                 = 1'b1;
    auto_en             = 1'b1;
    ack_man             = 1'b0;
    bus.frequency       = 0.0;
    bus.frequency_valid = 1'b0;

    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_eq_code", int'(bus.eq_code), 8);
    check("rst_valid", int'(bus.eq_code_valid), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // 2: on-target estimates build up lock; no offers expected
    for (int i = 0; i < 4; i++) begin
      pulse(3.1e9);
      check("lock_build", int'(bus.locked), (i == 3) ? 1 : 0);
      check("lock_busy", int'(bus.busy), 0);
    end
    repeat (3) @(negedge clk);

    // 3: target 12 from 8 -> offers 10, 12; lock drops on the first decision
    push(10, 1'b0);
    push(12, 1'b1);
    pulse(4.0e9);
    check("t3_unlock", int'(bus.locked), 0);
    check("t3_busy", int'(bus.busy), 1);
    wait_done("t3");
    check("t3_eq_code", int'(bus.eq_code), 12);
    check("t3_locked", int'(bus.locked), 0);
    check("t3_busy_end", int'(bus.busy), 0);

    // 4: clamp low (0) then clamp high (63)
    do_reset();
    check("t4_rst_code", int'(bus.eq_code), 8);
    push(6, 1'b0);
    push(4, 1'b1);
    push(2, 1'b1);
    push(0, 1'b1);
    pulse(0.2e9);
    wait_done("t4_low");
    check("t4_low_code", int'(bus.eq_code), 0);
    push(2, 1'b0);
    for (int c = 4; c <= 62; c += 2) push(c, 1'b1);
    push(63, 1'b1);
    pulse(30.0e9);
    wait_done("t4_high");
    check("t4_high_code", int'(bus.eq_code), 63);

    // 5: ack withheld; estimates during WAIT_ACK/SETTLE are dropped
    auto_en = 1'b0;
    push(61, 1'b0);
    push(59, 1'b1);
    push(57, 1'b1);
    push(55, 1'b1);
    push(53, 1'b1);
    push(52, 1'b1);
    pulse(14.0e9);
    wait_valid(1'b1, "t5_offer");
    pulse(2.0e9);
    repeat (50) @(negedge clk);
    check("t5_hold_code", int'(bus.eq_code), 61);
    check("t5_hold_valid", int'(bus.eq_code_valid), 1);
    check("t5_hold_busy", int'(bus.busy), 1);
    auto_en = 1'b1;
    wait_valid(1'b0, "t5_ack");
    repeat (3) @(negedge clk);
    pulse(2.0e9);
    wait_done("t5");
    check("t5_eq_code", int'(bus.eq_code), 52);

    // 6: reset dominates a same-edge ack in WAIT_ACK; ack with no offer ignored
    auto_en = 1'b0;
    push(50, 1'b0);
    pulse(3.1e9);
    wait_valid(1'b1, "t6_offer");
    ack_man = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    check("t6_eq_code", int'(bus.eq_code), 8);
    check("t6_valid", int'(bus.eq_code_valid), 0);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_locked", int'(bus.locked), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_stray_ack_code", int'(bus.eq_code), 8);
    check("t6_stray_ack_busy", int'(bus.busy), 0);
    ack_man = 1'b0;
    repeat (30) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
